// File: rtl/i2c_sensor_slave_if.sv
// I2C pad-side bus signals for the sensor target: synchronous-free pad inputs and the
// open-drain SDA pull-down enable.
interface i2c_sensor_slave_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_sensor_slave.sv
// I2C target serving a 3-register sensor map (humidity, temperature, device ID) with a
// writable register pointer, auto-incrementing reads and per-transaction shadow snapshot.
module i2c_sensor_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h40,
    parameter logic [7:0] DEV_ID     = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    i2c_sensor_slave_if.slave         bus,
    input  logic [7:0]                humidity,
    input  logic [7:0]                temperature,
    output logic                      busy,
    output logic                      addr_hit,
    output logic                      rd_done
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE, WAIT_STOP
    } state_t;

    state_t      state;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl_q, sda_q;
    logic        scl_s, sda_s;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic        fall_q;
    logic [2:0]  bit_cnt;
    logic [6:0]  shreg;
    logic [1:0]  pointer;
    logic [7:0]  hum_sh, temp_sh;
    logic [7:0]  rd_data;
    logic        rw_q, phase, wr_first, sda_oe_r;

    assign bus.sda_oe = sda_oe_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_in};
            sda_sync <= {sda_sync[0], bus.sda_in};
            scl_q    <= scl_sync[1];
            sda_q    <= sda_sync[1];
        end
    end

    // START/STOP need SCL high on both the current and previous sample, so SDA
    // activity while SCL is low never decodes as a bus condition.
    always_comb begin
        scl_s     = scl_sync[1];
        sda_s     = sda_sync[1];
        scl_rise  = scl_s & ~scl_q;
        scl_fall  = ~scl_s & scl_q;
        start_det = scl_s & scl_q & sda_q & ~sda_s;
        stop_det  = scl_s & scl_q & ~sda_q & sda_s;
    end

    always_comb begin
        rd_data = 8'hFF;
        case (pointer)
            2'd0:    rd_data = hum_sh;
            2'd1:    rd_data = temp_sh;
            2'd2:    rd_data = DEV_ID;
            default: rd_data = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fall_q   <= 1'b0;
            bit_cnt  <= '0;
            shreg    <= '0;
            pointer  <= '0;
            hum_sh   <= '0;
            temp_sh  <= '0;
            rw_q     <= 1'b0;
            phase    <= 1'b0;
            wr_first <= 1'b0;
            sda_oe_r <= 1'b0;
            busy     <= 1'b0;
            addr_hit <= 1'b0;
            rd_done  <= 1'b0;
        end else begin
            addr_hit <= 1'b0;
            rd_done  <= 1'b0;
            fall_q   <= scl_fall;
            if (stop_det) begin
                state    <= IDLE;
                sda_oe_r <= 1'b0;
                busy     <= 1'b0;
            end else if (start_det) begin
                state    <= ADDR;
                bit_cnt  <= '0;
                phase    <= 1'b0;
                sda_oe_r <= 1'b0;
            end else begin
                case (state)
                    IDLE, IGNORE, WAIT_STOP: sda_oe_r <= 1'b0;
                    ADDR: if (scl_rise) begin
                        shreg   <= {shreg[5:0], sda_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (shreg == SLAVE_ADDR) begin
                                state    <= ADDR_ACK;
                                addr_hit <= 1'b1;
                                busy     <= 1'b1;
                                rw_q     <= sda_s;
                                phase    <= 1'b0;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    // phase 0: first SCL fall drives ACK; phase 1: next fall releases it.
                    // Read snapshot is taken as the ACK is driven so the first data bit
                    // can be presented from the shadow registers on the release edge.
                    ADDR_ACK, WR_ACK: if (fall_q) begin
                        if (!phase) begin
                            sda_oe_r <= 1'b1;
                            phase    <= 1'b1;
                            if (state == ADDR_ACK && rw_q) begin
                                hum_sh  <= humidity;
                                temp_sh <= temperature;
                            end
                        end else begin
                            phase   <= 1'b0;
                            bit_cnt <= '0;
                            if (state == ADDR_ACK && rw_q) begin
                                state    <= RD_BYTE;
                                sda_oe_r <= ~rd_data[7];
                            end else begin
                                state    <= WR_BYTE;
                                sda_oe_r <= 1'b0;
                                if (state == ADDR_ACK)
                                    wr_first <= 1'b1;
                            end
                        end
                    end
                    WR_BYTE: if (scl_rise) begin
                        shreg   <= {shreg[5:0], sda_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (wr_first)
                                pointer <= {shreg[0], sda_s};
                            wr_first <= 1'b0;
                            phase    <= 1'b0;
                            state    <= WR_ACK;
                        end
                    end
                    RD_BYTE: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                phase <= 1'b1;
                        end else if (fall_q) begin
                            if (phase) begin
                                sda_oe_r <= 1'b0;
                                phase    <= 1'b0;
                                bit_cnt  <= '0;
                                state    <= RD_ACK;
                            end else begin
                                sda_oe_r <= ~rd_data[3'd7 - bit_cnt];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            rd_done <= 1'b1;
                            pointer <= (pointer == 2'd2) ? 2'd0 : pointer + 2'd1;
                            if (sda_s)
                                state <= WAIT_STOP;
                            else
                                phase <= 1'b1;
                        end else if (fall_q && phase) begin
                            phase    <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= RD_BYTE;
                            sda_oe_r <= ~rd_data[7];
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        sda_oe_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_sensor_slave.sv
// Directed bench for i2c_sensor_slave: bit-banged I2C master on a wired-AND SDA model.
module tb_i2c_sensor_slave;
    localparam int Q = 20;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       force_raw = 1'b0;
    logic [7:0] humidity = 8'd0;
    logic [7:0] temperature = 8'd0;
    logic       busy, addr_hit, rd_done;

    int n_checks = 0;
    int n_errors = 0;
    int hit_cnt = 0;
    int done_cnt = 0;
    int oe_cnt = 0;

    always #5 clk = ~clk;

    i2c_sensor_slave_if ifc ();
    assign ifc.scl_in = scl_m;
    assign ifc.sda_in = force_raw ? sda_m : (sda_m & ~ifc.sda_oe);

    i2c_sensor_slave #(.SLAVE_ADDR(7'h40), .DEV_ID(8'hA5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (ifc.slave),
        .humidity    (humidity),
        .temperature (temperature),
        .busy        (busy),
        .addr_hit    (addr_hit),
        .rd_done     (rd_done)
    );

    always @(posedge clk) begin
        if (addr_hit)   hit_cnt++;
        if (rd_done)    done_cnt++;
        if (ifc.sda_oe) oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic qd();
        #(Q * 10);
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        sda_m = b;
        qd();
        scl_m = 1'b1;
        qd();
        s = ifc.sda_in;
        qd();
        scl_m = 1'b0;
        qd();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        qd();
        scl_m = 1'b1;
        qd();
        sda_m = 1'b0;
        qd();
        scl_m = 1'b0;
        qd();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        qd();
        scl_m = 1'b1;
        qd();
        sda_m = 1'b1;
        qd();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(nack, s);
    endtask

    task automatic txn1(input string pfx);
        logic       a;
        logic [7:0] d;
        int         d0, h0;
        temperature = 8'd27;
        d0 = done_cnt;
        h0 = hit_cnt;
        i2c_start();
        write_byte(8'h80, a);
        check({pfx, "_ack_addr_w"}, 32'(a), 32'd0);
        check({pfx, "_busy"}, 32'(busy), 32'd1);
        write_byte(8'h01, a);
        check({pfx, "_ack_ptr"}, 32'(a), 32'd0);
        i2c_start();
        write_byte(8'h81, a);
        check({pfx, "_ack_addr_r"}, 32'(a), 32'd0);
        read_byte(d, 1'b1);
        check({pfx, "_rd_temp"}, 32'(d), 32'h1B);
        i2c_stop();
        check({pfx, "_rd_done_cnt"}, 32'(done_cnt - d0), 32'd1);
        check({pfx, "_addr_hit_cnt"}, 32'(hit_cnt - h0), 32'd2);
        check({pfx, "_busy_after_stop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic       a, s;
        logic [7:0] d;
        logic [7:0] v;
        int         h0, o0, d0;

        #50;
        check("rst_sda_oe", 32'(ifc.sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr_hit", 32'(addr_hit), 32'd0);
        check("rst_rd_done", 32'(rd_done), 32'd0);
        #50 rst_n = 1'b1;
        #100;

        txn1("t1");

        humidity = 8'd68;
        temperature = 8'd22;
        d0 = done_cnt;
        i2c_start();
        write_byte(8'h80, a);
        write_byte(8'h00, a);
        i2c_start();
        write_byte(8'h81, a);
        read_byte(d, 1'b0);
        check("t2_byte0", 32'(d), 32'h44);
        read_byte(d, 1'b0);
        check("t2_byte1", 32'(d), 32'h16);
        read_byte(d, 1'b1);
        check("t2_byte2", 32'(d), 32'hA5);
        i2c_stop();
        check("t2_rd_done_cnt", 32'(done_cnt - d0), 32'd3);
        i2c_start();
        write_byte(8'h81, a);
        read_byte(d, 1'b1);
        i2c_stop();
        check("t2_wrap_to_0", 32'(d), 32'h44);

        humidity = 8'd75;
        i2c_start();
        write_byte(8'h80, a);
        write_byte(8'h00, a);
        i2c_start();
        write_byte(8'h81, a);
        fork
            read_byte(d, 1'b1);
            begin
                #(Q * 10 * 4 * 3);
                humidity = 8'd60;
            end
        join
        i2c_stop();
        check("t3_snapshot", 32'(d), 32'h4B);

        h0 = hit_cnt;
        o0 = oe_cnt;
        i2c_start();
        write_byte(8'h84, a);
        check("t4_no_ack_addr", 32'(a), 32'd1);
        write_byte(8'h00, a);
        check("t4_no_ack_data", 32'(a), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        i2c_stop();
        check("t4_addr_hit_cnt", 32'(hit_cnt - h0), 32'd0);
        check("t4_sda_never_driven", 32'(oe_cnt - o0), 32'd0);

        humidity = 8'd68;
        i2c_start();
        write_byte(8'h80, a);
        write_byte(8'h00, a);
        i2c_start();
        write_byte(8'h81, a);
        check("t5_driving_zero", 32'(ifc.sda_oe), 32'd1);
        force_raw = 1'b1;
        sda_m = 1'b0;
        scl_m = 1'b1;
        qd();
        sda_m = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t5_release_after_stop", 32'(ifc.sda_oe), 32'd0);
        check("t5_busy_after_stop", 32'(busy), 32'd0);
        force_raw = 1'b0;
        qd();
        txn1("t5");

        humidity = 8'h33;
        i2c_start();
        v = 8'h80;
        for (int i = 7; i >= 0; i--) bit_xfer(v[i], s);
        check("t6_ack_driven", 32'(ifc.sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_release", 32'(ifc.sda_oe), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        #19 rst_n = 1'b1;
        i2c_stop();
        i2c_start();
        write_byte(8'h81, a);
        check("t6_ack_after_rst", 32'(a), 32'd0);
        read_byte(d, 1'b1);
        i2c_stop();
        check("t6_ptr_reset", 32'(d), 32'h33);
        txn1("t6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
